// File: rtl/tent_map_iter.sv
// Tent-map keystream generator: iterates y' = tent(y, alpha) with a bit-serial
// restoring divider and streams each masked iterate over a valid/ready handshake.
module tent_map_iter #(
    parameter int DATA_WIDTH = 12,
    parameter int ITER_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [ITER_W-1:0]     n_iter,
    input  logic [1:0]            precision_sel,
    output logic [DATA_WIDTH-1:0] key_out,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONES     = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO_D   = {DATA_WIDTH{1'b0}};
    localparam logic [ITER_W-1:0]     ZERO_C   = {ITER_W{1'b0}};
    localparam logic [ITER_W-1:0]     CNT_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]         BIT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0]         BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DIV   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] y_r, y_s;
    logic [ITER_W-1:0]     cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0] alpha_r, alpha_s;
    logic [1:0]            psel_r, psel_s;
    logic [DATA_WIDTH-1:0] rem_r, rem_s;
    logic [DATA_WIDTH-1:0] den_r, den_s;
    logic [DATA_WIDTH-1:0] quo_r, quo_s;
    logic                  sat_r, sat_s;
    logic [BW-1:0]         bit_r, bit_s;
    logic [DATA_WIDTH-1:0] key_out_r, key_out_s;
    logic                  key_valid_r, key_valid_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  err_r, err_s;

    logic [DATA_WIDTH:0]   shifted_s;
    logic                  qbit_s;
    logic [DATA_WIDTH-1:0] quo_next_s;
    logic [DATA_WIDTH-1:0] full_s;

    function automatic logic [DATA_WIDTH-1:0] key_mask(input logic [1:0] sel);
        logic [DATA_WIDTH-1:0] m;
        case (sel)
            2'b00:   m = ONES;
            2'b01:   m = ONES << 3'd2;
            2'b10:   m = ONES << 3'd4;
            2'b11:   m = ONES << (DATA_WIDTH / 2);
            default: m = ONES;
        endcase
        return m;
    endfunction

    // One restoring-division step; the partial remainder always stays below den,
    // so the difference fits back into DATA_WIDTH bits.
    assign shifted_s  = {rem_r, 1'b0};
    assign qbit_s     = (shifted_s >= {1'b0, den_r});
    assign quo_next_s = {quo_r[DATA_WIDTH-2:0], qbit_s};
    assign full_s     = sat_r ? ONES : quo_next_s;

    // State and datapath register; clear acts exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_r     <= IDLE;
            y_r         <= ZERO_D;
            cnt_r       <= ZERO_C;
            alpha_r     <= ZERO_D;
            psel_r      <= 2'b00;
            rem_r       <= ZERO_D;
            den_r       <= ZERO_D;
            quo_r       <= ZERO_D;
            sat_r       <= 1'b0;
            bit_r       <= BIT_ZERO;
            key_out_r   <= ZERO_D;
            key_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            y_r         <= y_s;
            cnt_r       <= cnt_s;
            alpha_r     <= alpha_s;
            psel_r      <= psel_s;
            rem_r       <= rem_s;
            den_r       <= den_s;
            quo_r       <= quo_s;
            sat_r       <= sat_s;
            bit_r       <= bit_s;
            key_out_r   <= key_out_s;
            key_valid_r <= key_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    // Next-state and next-register computation.
    always_comb begin
        state_s     = state_r;
        y_s         = y_r;
        cnt_s       = cnt_r;
        alpha_s     = alpha_r;
        psel_s      = psel_r;
        rem_s       = rem_r;
        den_s       = den_r;
        quo_s       = quo_r;
        sat_s       = sat_r;
        bit_s       = bit_r;
        key_out_s   = key_out_r;
        key_valid_s = key_valid_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (alpha == ZERO_D) begin
                        err_s = 1'b1;
                    end else if (n_iter == ZERO_C) begin
                        done_s = 1'b1;
                    end else begin
                        y_s     = seed;
                        cnt_s   = n_iter;
                        alpha_s = alpha;
                        psel_s  = precision_sel;
                        state_s = SETUP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                // Falling branch: y >= alpha maps through (1-y)/(1-alpha).
                if (y_r < alpha_r) begin
                    rem_s = y_r;
                    den_s = alpha_r;
                    sat_s = 1'b0;
                end else begin
                    rem_s = ZERO_D - y_r;
                    den_s = ZERO_D - alpha_r;
                    sat_s = (y_r == alpha_r);
                end
                quo_s   = ZERO_D;
                bit_s   = BIT_LAST;
                state_s = DIV;
            end
            DIV: begin
                if (qbit_s) begin
                    rem_s = shifted_s[DATA_WIDTH-1:0] - den_r;
                end else begin
                    rem_s = shifted_s[DATA_WIDTH-1:0];
                end
                quo_s = quo_next_s;
                if (bit_r == BIT_ZERO) begin
                    y_s         = full_s;
                    key_out_s   = full_s & key_mask(psel_r);
                    key_valid_s = 1'b1;
                    state_s     = OUT;
                end else begin
                    bit_s = bit_r - BIT_ONE;
                end
            end
            OUT: begin
                if (key_ready) begin
                    key_valid_s = 1'b0;
                    cnt_s       = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = SETUP;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    assign key_out   = key_out_r;
    assign key_valid = key_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_tent_map_iter.sv
// Directed self-checking bench for tent_map_iter with hand-computed keys.
module tb_tent_map_iter;

    localparam int DW = 12;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_n, clear, start, key_ready;
    logic [DW-1:0] seed, alpha;
    logic [IW-1:0] n_iter;
    logic [1:0]    precision_sel;
    logic [DW-1:0] key_out;
    logic          key_valid, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    tent_map_iter #(.DATA_WIDTH(DW), .ITER_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .seed(seed), .alpha(alpha), .n_iter(n_iter), .precision_sel(precision_sel),
        .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic do_start(input logic [DW-1:0] s, input logic [DW-1:0] a,
                            input logic [IW-1:0] n, input logic [1:0] p);
        seed = s; alpha = a; n_iter = n; precision_sel = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!key_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!key_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Waits for a key with key_ready high, checks it, and lets it transfer.
    task automatic expect_key(input string tag, input logic [DW-1:0] exp,
                              input bit chk_lat, input bit last);
        int lat;
        wait_valid(lat);
        if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'd14);
        check(tag, 32'(key_out), 32'(exp));
        @(negedge clk);
        if (last) begin
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd0);
        end else begin
            check({tag, "_nodone"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [DW-1:0] k0;
        bit any_busy, any_valid, any_done;

        rst_n = 1'b0; clear = 1'b0; start = 1'b0; key_ready = 1'b1;
        seed = '0; alpha = '0; n_iter = '0; precision_sel = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_key", 32'(key_out), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sequence including the saturation case y == alpha
        do_start(12'h400, 12'h800, 8'd3, 2'b00);
        check("t1_busy", 32'(busy), 32'd1);
        expect_key("t1_k1", 12'h800, 1'b1, 1'b0);
        expect_key("t1_k2", 12'hFFF, 1'b1, 1'b0);
        expect_key("t1_k3", 12'h002, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // Mask on output only, feedback unmasked
        do_start(12'h123, 12'h800, 8'd2, 2'b01);
        expect_key("t2_k1", 12'h244, 1'b1, 1'b0);
        expect_key("t2_k2", 12'h48C, 1'b1, 1'b1);

        // Backpressure
        key_ready = 1'b0;
        do_start(12'h400, 12'h800, 8'd2, 2'b00);
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd14);
        check("bp_k1", 32'(key_out), 32'h800);
        k0 = key_out;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(key_valid), 32'd1);
            check("bp_hold", 32'(key_out), 32'(k0));
        end
        key_ready = 1'b1;
        @(negedge clk);
        check("bp_drop", 32'(key_valid), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        expect_key("bp_k2", 12'hFFF, 1'b1, 1'b1);

        // alpha == 0 rejected
        do_start(12'h123, 12'h000, 8'd2, 2'b00);
        check("a0_err", 32'(err), 32'd1);
        check("a0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("a0_err_pulse", 32'(err), 32'd0);
        any_busy = 1'b0; any_valid = 1'b0;
        repeat (16) begin
            @(negedge clk);
            any_busy  |= busy;
            any_valid |= key_valid;
        end
        check("a0_quiet_busy", 32'(any_busy), 32'd0);
        check("a0_quiet_valid", 32'(any_valid), 32'd0);
        do_start(12'h123, 12'h800, 8'd1, 2'b10);
        expect_key("a0_after", 12'h240, 1'b1, 1'b1);
        do_start(12'hC00, 12'h400, 8'd1, 2'b11);
        expect_key("fall_half", 12'h540, 1'b1, 1'b1);

        // clear mid-DIV of the second iteration, with a colliding start
        do_start(12'h400, 12'h800, 8'd3, 2'b00);
        expect_key("clr_k1", 12'h800, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check("clr_key", 32'(key_out), 32'd0);
        check("clr_valid", 32'(key_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        any_busy = 1'b0; any_valid = 1'b0; any_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_busy  |= busy;
            any_valid |= key_valid;
            any_done  |= done;
        end
        check("clr_idle_busy", 32'(any_busy), 32'd0);
        check("clr_idle_done", 32'(any_done), 32'd0);
        check("clr_idle_valid", 32'(any_valid), 32'd0);
        do_start(12'h600, 12'h800, 8'd1, 2'b00);
        expect_key("clr_restart", 12'hC00, 1'b1, 1'b1);

        // n_iter == 0, then a start pulse while busy
        do_start(12'h400, 12'h800, 8'd0, 2'b00);
        check("n0_done", 32'(done), 32'd1);
        check("n0_busy", 32'(busy), 32'd0);
        check("n0_valid", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("n0_done_pulse", 32'(done), 32'd0);
        do_start(12'h400, 12'h800, 8'd2, 2'b00);
        repeat (3) @(negedge clk);
        seed = 12'h123; alpha = 12'h000; n_iter = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_err", 32'(err), 32'd0);
        expect_key("busy_k1", 12'h800, 1'b0, 1'b0);
        expect_key("busy_k2", 12'hFFF, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tent_map_iter.md
# tent_map_iter

Multi-iteration, parametrised tent-map keystream generator. It replaces the single-shot combinational-divide tent core with a bit-serial restoring divider. It iterates the map a programmable number of times from one seed and streams each iterate out over a valid/ready handshake. It sits after the seed/alpha generation stage and feeds the key-combining stage.

## Interface
- DATA_WIDTH, 12, fixed-point width of y, alpha and keys (unsigned fraction, value = x/2^DATA_WIDTH)
- ITER_W, 8, width of the iteration-count input
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous abort; returns block to IDLE next cycle
- start  in  1  single-cycle request; sampled only in IDLE
- seed  in  DATA_WIDTH  initial y, latched on accepted start
- alpha  in  DATA_WIDTH  tent breakpoint, latched on accepted start
- n_iter  in  ITER_W  number of keys to produce, latched on accepted start
- precision_sel  in  2  output mask, latched on accepted start
- key_out  out  DATA_WIDTH  current iterate, masked
- key_valid  out  1  key_out valid
- key_ready  in  1  downstream accepts key_out
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last key is accepted
- err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, SETUP, DIV, OUT.
- IDLE: if start is high and alpha == 0, start is rejected. err pulses, registers stay unchanged, and the block remains in IDLE.
- IDLE: if start is high and n_iter == 0, done pulses next cycle and no keys are produced.
- IDLE: otherwise the block latches its inputs, sets y = seed and cnt = n_iter, and moves to SETUP.
- SETUP:
  - If y < alpha: num = y, den = alpha.
  - Otherwise: num = (2^DW − y) mod 2^DW, den = 2^DW − alpha.
  - Dividend = num·2^DW; quotient is cleared. Next state is DIV.
- DIV: restoring division producing one quotient bit per cycle, MSB first, for exactly DATA_WIDTH cycles. Then go to OUT.
- Overflow rule: num ≥ den occurs only when y == alpha. In that case the quotient saturates to all-ones (2^DW−1). Otherwise the quotient is floor(num·2^DW/den).
- OUT: key_valid = 1 and key_out = quotient & mask.
  - Feedback y = full-precision quotient; the mask is never applied to feedback.
  - On key_valid & key_ready: cnt decrements.
  - If cnt becomes 0: done pulses and the block returns to IDLE.
  - Else: go to SETUP with the new y.
- Mask by precision_sel:
  - 00: none.
  - 01: clear 2 LSBs.
  - 10: clear 4 LSBs.
  - 11: clear DATA_WIDTH/2 LSBs.
- start outside IDLE is ignored; err stays low.
- Reset / clear behaviour:
  - clear has priority over every state transition and handshake.
  - clear or rst_n low: state = IDLE, key_out = 0, key_valid = 0, busy = 0, done = 0, err = 0, internal y/cnt = 0.
  - clear in OUT drops key_valid without a transfer.

## Timing
- Reset values: key_out 0, key_valid 0, busy 0, done 0, err 0.
- Start accepted at edge T: busy = 1 from T+1, SETUP at T+1, DIV at T+2..T+DW+1, key_valid at T+DW+2 (14 cycles for DW = 12).
- Key accepted at edge A: SETUP at A+1, next key_valid at A+DW+2. With key_ready held high, the sustained rate is one key per DW+2 cycles.
- key_out and key_valid are registered. They stay stable while key_valid & !key_ready.
- done: asserted the cycle after the last transfer; busy is 0 in that same cycle.
- err: asserted the cycle after the rejected start.
- start and clear in the same cycle: clear wins and start is dropped.

## Test plan
- DW=12, seed=0x400, alpha=0x800, n_iter=3, ready=1 → keys 0x800, 0xFFF (saturation), 0x002; done one cycle after the third transfer; first key_valid 14 cycles after start.
- seed=0x123, alpha=0x800, n_iter=2, precision_sel=01 → keys 0x244, 0x48C (feedback unmasked: second key derived from 0x246).
- Backpressure: hold key_ready=0 for 5 cycles in OUT → key_out/key_valid stable, no new SETUP; 1 cycle after ready, SETUP entered.
- alpha=0 with start → err pulse, busy stays 0, no key_valid; later valid start works normally.
- clear asserted mid-DIV of second iteration → next cycle IDLE, all outputs 0, no done; new start yields correct first key.
- n_iter=0 start → done pulse next cycle, no key_valid; start pulsed while busy → ignored, sequence unchanged.
